// File: rtl/nn_pkg.sv
// Shared constants for the convolution datapath: word widths, fixed-point
// scaling and the layer state codes driven onto the weight/bias ROMs.
package nn_pkg;

  localparam int unsigned DATSIZE = 22;  // signed feature word
  localparam int unsigned PARSIZE = 16;  // signed weight / bias word
  localparam int unsigned FPSHIFT = 14;  // fraction bits of data and params
  localparam int unsigned ACCW    = 48;  // signed accumulator
  localparam int unsigned CW      = 6;   // channel index width
  localparam int unsigned MAXCH   = 32;  // largest channel count swept

  // Nine full-width products summed need 4 extra bits of headroom.
  localparam int unsigned PSUMW = DATSIZE + PARSIZE + 4;

  localparam logic [3:0] CONV1 = 4'b0010;
  localparam logic [3:0] CONV2 = 4'b0100;
  localparam logic [3:0] CONV3 = 4'b0110;

endpackage

// File: rtl/mac9_tree.sv
// Stage A: nine signed weight x data products summed into one registered
// partial sum; a valid bit travels alongside so bubbles are never accumulated.
module mac9_tree
  import nn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [9*PARSIZE-1:0]     w,
  input  logic [9*DATSIZE-1:0]     d,
  output logic signed [PSUMW-1:0]  psum,
  output logic                     psum_valid
);

  localparam int unsigned PRODW = PARSIZE + DATSIZE;

  logic signed [PARSIZE-1:0] w_tap [9];
  logic signed [DATSIZE-1:0] d_tap [9];
  logic signed [PRODW-1:0]   prod  [9];
  logic signed [PSUMW-1:0]   sum;

  // Unpack taps, multiply at full width and sum through the adder tree.
  always_comb begin
    sum = '0;
    for (int k = 0; k < 9; k++) begin
      w_tap[k] = w[k*PARSIZE +: PARSIZE];
      d_tap[k] = d[k*DATSIZE +: DATSIZE];
      prod[k]  = w_tap[k] * d_tap[k];
      sum      = sum + PSUMW'(prod[k]);
    end
  end

  // Register the partial sum only for valid taps to keep idle toggling low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum       <= '0;
      psum_valid <= 1'b0;
    end else begin
      psum_valid <= in_valid;
      if (in_valid) begin
        psum <= sum;
      end
    end
  end

endmodule

// File: rtl/conv3x3_mac.sv
// One output pixel of one output channel: sweep input channels, fetch kernels,
// accumulate 3x3 dot products, add bias, rescale, ReLU and saturate.
module conv3x3_mac
  import nn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            layer_state,
  input  logic [CW:0]           n_in,
  input  logic [CW-1:0]         out_ch,
  output logic [3:0]            w_state,
  output logic                  w_en,
  output logic [CW-1:0]         read_c,
  output logic [CW-1:0]         read_o,
  input  logic [9*PARSIZE-1:0]  w_data,
  input  logic [9*DATSIZE-1:0]  win_data,
  input  logic [PARSIZE-1:0]    bias_in,
  output logic                  busy,
  output logic                  out_valid,
  output logic [DATSIZE-1:0]    out_data
);

  typedef enum logic [2:0] {StIdle, StIssue, StDrain1, StDrain2, StFinish} state_e;

  localparam logic [CW:0] MaxCh = MAXCH[CW:0];
  localparam logic signed [ACCW-1:0] DatMax =
    {{(ACCW-DATSIZE+1){1'b0}}, {(DATSIZE-1){1'b1}}};

  state_e                   state_q, state_d;
  logic [CW:0]              n_q;
  logic [CW-1:0]            read_c_q, read_o_q;
  logic [3:0]               w_state_q;
  logic                     busy_q, out_valid_q, data_v_q;
  logic [DATSIZE-1:0]       out_data_q;
  logic signed [ACCW-1:0]   acc_q;
  logic signed [PSUMW-1:0]  psum;
  logic                     psum_valid;

  logic                     start_ok, last_issue, issuing;
  logic [CW:0]              n_clamped;
  logic signed [ACCW-1:0]   bias_ext, sum_s, shr_s;
  logic [DATSIZE-1:0]       result;

  assign n_clamped  = (n_in > MaxCh) ? MaxCh : n_in;
  assign start_ok   = start && !busy_q && (state_q == StIdle);
  assign issuing    = (state_q == StIssue);
  assign last_issue = ({1'b0, read_c_q} == (n_q - 1'b1));

  assign w_state   = w_state_q;
  assign w_en      = issuing;
  assign read_c    = read_c_q;
  assign read_o    = read_o_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Next-state sequencing of the channel sweep and pipeline flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_ok) state_d = (n_clamped == '0) ? StDrain1 : StIssue;
      StIssue:  if (last_issue) state_d = StDrain1;
      StDrain1: state_d = StDrain2;
      StDrain2: state_d = StFinish;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Bias add, rescale to data fraction bits, ReLU then clip to the data range.
  always_comb begin
    bias_ext = ACCW'($signed(bias_in));
    sum_s    = acc_q + (bias_ext <<< FPSHIFT);
    shr_s    = sum_s >>> FPSHIFT;
    if (shr_s[ACCW-1]) begin
      result = '0;
    end else if (shr_s > DatMax) begin
      result = DatMax[DATSIZE-1:0];
    end else begin
      result = shr_s[DATSIZE-1:0];
    end
  end

  // Control state, request latches, channel counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      n_q         <= '0;
      read_c_q    <= '0;
      read_o_q    <= '0;
      w_state_q   <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      data_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_v_q    <= issuing;  // ROM and window data arrive one cycle later
      out_valid_q <= 1'b0;
      if (start_ok) begin
        w_state_q <= layer_state;
        read_o_q  <= out_ch;
        n_q       <= n_clamped;
        read_c_q  <= '0;
        busy_q    <= 1'b1;
      end else if (issuing && !last_issue) begin
        read_c_q <= read_c_q + 1'b1;
      end
      if (state_q == StFinish) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result;
        busy_q      <= 1'b0;
      end
    end
  end

  // Stage B: accumulate valid partial sums; cleared on each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (start_ok) begin
      acc_q <= '0;
    end else if (psum_valid) begin
      acc_q <= acc_q + ACCW'(psum);
    end
  end

  mac9_tree u_mac9_tree (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (data_v_q),
    .w          (w_data),
    .d          (win_data),
    .psum       (psum),
    .psum_valid (psum_valid)
  );

endmodule

// File: tb/tb_conv3x3_mac.sv
// Bench for conv3x3_mac: behavioural weight ROM and window source, expected
// results queued at start and compared when out_valid fires.
module tb_conv3x3_mac;
  import nn_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [3:0]           layer_state = '0;
  logic [CW:0]          n_in = '0;
  logic [CW-1:0]        out_ch = '0;
  logic [3:0]           w_state;
  logic                 w_en;
  logic [CW-1:0]        read_c;
  logic [CW-1:0]        read_o;
  logic [9*PARSIZE-1:0] w_data = '0;
  logic [9*DATSIZE-1:0] win_data = '0;
  logic [PARSIZE-1:0]   bias_in;
  logic                 busy;
  logic                 out_valid;
  logic [DATSIZE-1:0]   out_data;

  always #5 clk = ~clk;

  conv3x3_mac dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .layer_state (layer_state),
    .n_in        (n_in),
    .out_ch      (out_ch),
    .w_state     (w_state),
    .w_en        (w_en),
    .read_c      (read_c),
    .read_o      (read_o),
    .w_data      (w_data),
    .win_data    (win_data),
    .bias_in     (bias_in),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_data    (out_data)
  );

  typedef struct {
    longint data;
    int     cyc;
  } exp_t;

  int     w_arr [64][9];
  int     d_arr [64][9];
  int     bias_v = 0;
  exp_t   sb [$];
  exp_t   mon_e;
  int     cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     ov_cnt = 0;
  int     wen_cnt = 0;
  int     exp_c = 0;
  int     n_pushed = 0;

  assign bias_in = PARSIZE'(bias_v);

  always @(posedge clk) cyc <= cyc + 1;

  // Weight ROM: registered, one cycle after w_en.
  always @(posedge clk) begin
    if (w_en) begin
      for (int k = 0; k < 9; k++) w_data[k*PARSIZE +: PARSIZE] <= PARSIZE'(w_arr[read_c][k]);
    end
  end

  // Window source: the window for read_c, one cycle later.
  always @(posedge clk) begin
    for (int k = 0; k < 9; k++) win_data[k*DATSIZE +: DATSIZE] <= DATSIZE'(d_arr[read_c][k]);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard pop on every result; also track the channel fetch order.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      ov_cnt++;
      if (sb.size() == 0) begin
        check("unexpected out_valid", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("out_data", longint'($signed(out_data)), mon_e.data);
        check("latency", cyc, mon_e.cyc);
      end
    end
    if (rst_n && w_en) begin
      check("read_c order", longint'(read_c), exp_c);
      exp_c++;
      wen_cnt++;
    end
  end

  task automatic fill(input int wv, input int dv);
    for (int c = 0; c < 64; c++)
      for (int k = 0; k < 9; k++) begin
        w_arr[c][k] = wv;
        d_arr[c][k] = dv;
      end
  endtask

  function automatic longint model(input int n, input int b);
    longint acc;
    int     nn;
    acc = 0;
    nn  = (n > 32) ? 32 : n;
    for (int c = 0; c < nn; c++)
      for (int k = 0; k < 9; k++) acc += longint'(w_arr[c][k]) * longint'(d_arr[c][k]);
    acc = acc + longint'(b) * 16384;
    acc = acc >>> 14;
    if (acc < 0) return 0;
    if (acc > 2097151) return 2097151;
    return acc;
  endfunction

  // Pulse start for one cycle; queue the expected result with its due cycle.
  task automatic run_op(input logic [3:0] ls, input int n, input logic [CW-1:0] och,
                        input longint expv, input bit push);
    exp_t e;
    int   nn;
    nn = (n > 32) ? 32 : n;
    @(negedge clk);
    layer_state = ls;
    n_in        = n[CW:0];
    out_ch      = och;
    start       = 1'b1;
    exp_c       = 0;
    wen_cnt     = 0;
    if (push) begin
      e.data = expv;
      e.cyc  = cyc + nn + 4;
      sb.push_back(e);
      n_pushed++;
    end
    @(negedge clk);
    start = 1'b0;
    check("busy after start", longint'(busy), 1);
    check("w_state latched", longint'(w_state), longint'(ls));
    check("read_o latched", longint'(read_o), longint'(och));
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!out_valid && i < budget);
    if (!out_valid) check("timeout waiting out_valid", 0, 1);
    else check("busy low with out_valid", longint'(busy), 0);
  endtask

  initial begin
    int b;
    fill(0, 0);
    repeat (3) @(negedge clk);
    check("reset busy", longint'(busy), 0);
    check("reset w_en", longint'(w_en), 0);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset out_data", longint'(out_data), 0);
    check("reset w_state", longint'(w_state), 0);
    check("reset read_c", longint'(read_c), 0);
    rst_n = 1'b1;

    // Unit kernel: 9 x 1.0 x 1.0
    fill(16384, 16384);
    bias_v = 0;
    run_op(CONV1, 1, 6'd3, 147456, 1'b1);
    wait_done(50);
    check("unit w_en pulses", wen_cnt, 1);

    // Centre-tap sweep over 16 channels, plus an ignored start while busy
    fill(0, 777);
    for (int c = 0; c < 64; c++) begin
      w_arr[c][4] = 16384;
      d_arr[c][4] = 1024 * c;
    end
    bias_v = 8192;
    run_op(CONV2, 16, 6'd5, 131072, 1'b1);
    repeat (2) @(negedge clk);
    layer_state = CONV3;
    n_in        = 7'd5;
    out_ch      = 6'd9;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("w_state held while busy", longint'(w_state), longint'(CONV2));
    check("read_o held while busy", longint'(read_o), 5);
    wait_done(80);
    check("sweep w_en pulses", wen_cnt, 16);

    // Negative result clamps to zero
    fill(-16384, 16384);
    bias_v = 0;
    run_op(CONV1, 1, 6'd0, 0, 1'b1);
    wait_done(50);

    // Large positive result saturates
    fill(32767, 2097151);
    run_op(CONV3, 32, 6'd1, 2097151, 1'b1);
    wait_done(80);
    check("sat w_en pulses", wen_cnt, 32);

    // No input channels: bias only
    bias_v = -100;
    run_op(CONV1, 0, 6'd2, 0, 1'b1);
    wait_done(50);
    check("n_in=0 w_en pulses", wen_cnt, 0);
    bias_v = 300;
    run_op(CONV2, 0, 6'd2, 300, 1'b1);
    wait_done(50);

    // Random kernels, including channel counts above the clamp
    for (int t = 0; t < 3; t++) begin
      int n;
      n = (t == 0) ? 40 : (t == 1) ? 7 : 33;
      for (int c = 0; c < 64; c++)
        for (int k = 0; k < 9; k++) begin
          w_arr[c][k] = int'($urandom_range(2500)) - 500;
          d_arr[c][k] = int'($urandom_range(100000)) - 30000;
        end
      b = int'($urandom_range(2000)) - 1000;
      bias_v = b;
      run_op(CONV3, n, 6'(t), model(n, b), 1'b1);
      wait_done(80);
      check("random w_en pulses", wen_cnt, (n > 32) ? 32 : n);
    end

    // Reset in the middle of a long run: nothing comes out afterwards
    bias_v = 300;
    run_op(CONV2, 0, 6'd0, 300, 1'b1);
    wait_done(50);
    fill(16384, 16384);
    run_op(CONV2, 16, 6'd4, 0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", longint'(busy), 0);
    check("mid reset w_en", longint'(w_en), 0);
    check("mid reset out_valid", longint'(out_valid), 0);
    check("mid reset out_data", longint'(out_data), 0);
    check("mid reset read_c", longint'(read_c), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wen_cnt = 0;
    repeat (40) @(negedge clk);
    check("w_en after reset", wen_cnt, 0);
    check("out_valid count", ov_cnt, n_pushed);
    check("scoreboard empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Convolution compute stage directly downstream of conv_weights / conv_biases.
- For one output channel and one output pixel, it:
  - sweeps the input channels,
  - issues weight-ROM reads,
  - multiplies each returned 9-tap kernel against the matching 3x3 data window,
  - accumulates, adds the bias, rescales by FPSHIFT, applies ReLU and saturates to a DATSIZE result.
- The layer controller fires it once per (pixel, output channel). The result goes to the feature-map writer.

Parameters:
- DATSIZE, 22, signed feature word width (fixed point, FPSHIFT fraction bits).
- PARSIZE, 16, signed weight/bias width (FPSHIFT fraction bits).
- FPSHIFT, 14, fraction bits of data and params.
- ACCW, 48, signed accumulator width; must hold 64 x 9 x (DATSIZE+PARSIZE)-bit products.
- CW, 6, channel index width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request pulse; sampled only when busy=0.
- layer_state  in  4  layer code (0010 CONV1, 0100 CONV2, 0110 CONV3); latched at start.
- n_in  in  CW+1  number of input channels (0..32); latched at start.
- out_ch  in  CW  output channel index; latched at start.
- w_state  out  4  latched layer code, to the weight/bias ROM state inputs.
- w_en  out  1  weight ROM enable.
- read_c  out  CW  input channel being fetched.
- read_o  out  CW  latched out_ch.
- w_data  in  9*PARSIZE  ROM output, valid 1 cycle after w_en; tap k at bits [k*PARSIZE +: PARSIZE].
- win_data  in  9*DATSIZE  3x3 window for channel read_c, presented 1 cycle after read_c, same tap order.
- bias_in  in  PARSIZE  combinational bias for (w_state, read_o).
- busy  out  1  high from the cycle after start until the cycle out_valid is high.
- out_valid  out  1  one-cycle result strobe.
- out_data  out  DATSIZE  signed result, held until the next out_valid.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - busy, w_en, out_valid = 0.
  - read_c, read_o, out_data, accumulator = 0.
  - w_state = 0000.
- FSM: IDLE -> ISSUE -> DRAIN1 -> DRAIN2 -> FINISH -> IDLE.
- IDLE:
  - On start: latch the inputs, clear the accumulator, set busy, read_c=0.
  - Go to ISSUE, or to DRAIN1 if n_in=0.
  - start while busy=1 is ignored.
- ISSUE:
  - w_en=1, read_c increments by 1 per cycle from 0 to n_in-1.
  - After issuing n_in-1, go to DRAIN1 with w_en=0.
- Pipeline:
  - Stage A (cycle after issue c): 9 signed products w_k*d_k, full width PARSIZE+DATSIZE, summed into a registered psum.
  - Stage B (next cycle): acc <= acc + sign-extended psum.
  - A valid bit travels with each stage; invalid bubbles must not accumulate.
- DRAIN1, DRAIN2: flush stages A and B.
- FINISH:
  - s = acc + (sext(bias_in) <<< FPSHIFT).
  - r = s >>> FPSHIFT (arithmetic, truncate toward -inf).
  - ReLU: r<0 -> 0.
  - r > 2^(DATSIZE-1)-1 -> saturate to 2^(DATSIZE-1)-1.
  - out_data <= r, out_valid=1 for exactly this cycle, busy drops the same cycle; next state IDLE.
- Latency:
  - start at cycle 0 gives out_valid at cycle n_in+4 (cycle 4 when n_in=0).
  - Back-to-back start is accepted on the cycle after out_valid.
- n_in=0: no ROM reads; result = relu/sat(bias).
- n_in > 32: clamp to 32.
- w_state/read_o stay stable from the cycle after start through FINISH, so bias_in is stable when sampled.
- Reset mid-operation: everything returns to reset values immediately; no out_valid is produced.

Decomposition:
- Shared package (nn_pkg):
  - DATSIZE/PARSIZE/FPSHIFT constants.
  - Layer state codes CONV1=0010, CONV2=0100, CONV3=0110.
  - ACCW.
- One sub-module: mac9_tree, a registered 9-tap signed multiply plus adder tree (stage A).
- FSM, accumulator and output rescale stay in conv3x3_mac.

Test Plan:
- Reset: hold rst_n=0 mid-run (n_in=16, cycle 5) -> busy, w_en, out_valid fall immediately, out_data=0, no later out_valid.
- CONV1 unit kernel:
  - Stimulus: n_in=1, all w=16384 (1.0), all d=16384, bias=0.
  - Response: out_valid at cycle 5, out_data=147456 (9.0), exactly 1 w_en pulse with read_c=0.
- CONV2 sweep:
  - Stimulus: n_in=16, w center tap=16384 and others 0, d center=1024*c for channel c, bias=8192.
  - Response: read_c 0..15 on consecutive cycles, out_data = 1024*120 + 8192 = 131072, out_valid at cycle 20.
- ReLU:
  - Stimulus: n_in=1, w=-16384 all taps, d=16384, bias=0.
  - Response: out_data=0.
- Saturation:
  - Stimulus: n_in=32, w=32767 all taps, d=2097151 all taps.
  - Response: out_data=2097151, no wrap.
- n_in=0 and start-while-busy:
  - n_in=0, bias=-100 -> out_data=0 at cycle 4, w_en never asserted.
  - A second start pulse during busy -> ignored; exactly one out_valid.
